// File: rtl/pixel_packer.sv
// Thresholds a raster stream of 8-bit gray pixels to 1 bit and packs 8 adjacent
// pixels (LSB = leftmost) into bytes written to the 1-bit image memory.
module pixel_packer #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [7:0]  pix_gray,
  input  logic        sof,
  input  logic [7:0]  threshold,
  output logic [7:0]  data,
  output logic [15:0] wraddress,
  output logic        wren,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned BYTES_PER_ROW = WIDTH / 8;
  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned AW = 16;

  typedef enum logic [1:0] {S_WAIT_SOF, S_ACTIVE, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   row_base_q, row_base_d;
  logic [7:0]      byte_q, byte_d;
  logic [7:0]      data_q, data_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wren_q, wren_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic            pix_bit_c, start_c, pack_c;
  logic            byte_end_c, line_end_c, frame_end_c;
  logic [XW-1:0]   pos_x_c;
  logic [YW-1:0]   pos_y_c;
  logic [AW-1:0]   pos_base_c;

  // A sof pixel is always position (0,0), regardless of the current counters.
  assign pix_bit_c   = pix_gray >= threshold;
  assign start_c     = pix_valid & sof;
  assign pack_c      = pix_valid & (sof | (state_q == S_ACTIVE));
  assign pos_x_c     = start_c ? '0 : x_q;
  assign pos_y_c     = start_c ? '0 : y_q;
  assign pos_base_c  = start_c ? '0 : row_base_q;
  assign byte_end_c  = pos_x_c[2:0] == 3'd7;
  assign line_end_c  = pos_x_c == XW'(WIDTH - 1);
  assign frame_end_c = line_end_c && (pos_y_c == YW'(HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT_SOF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_c) begin
      state_d = S_ACTIVE;
    end
    if (pack_c && frame_end_c) begin
      state_d = S_DONE;
    end
  end

  // Packing, counters and registered write-port values.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    byte_d     = byte_q;
    data_d     = data_q;
    addr_d     = addr_q;
    wren_d     = 1'b0;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    if (start_c) begin
      ovf_d = 1'b0;
    end else if (pix_valid && (state_q == S_DONE)) begin
      ovf_d = 1'b1;
    end
    if (pack_c) begin
      byte_d[pos_x_c[2:0]] = pix_bit_c;
      y_d        = pos_y_c;
      row_base_d = pos_base_c;
      x_d        = pos_x_c + XW'(1);
      if (byte_end_c) begin
        wren_d = 1'b1;
        data_d = byte_d;
        addr_d = pos_base_c + AW'(pos_x_c >> 3);
      end
      if (line_end_c) begin
        x_d = '0;
        if (frame_end_c) begin
          done_d = 1'b1;
        end else begin
          y_d        = pos_y_c + YW'(1);
          row_base_d = pos_base_c + AW'(BYTES_PER_ROW);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      byte_q     <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      wren_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      byte_q     <= byte_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      wren_q     <= wren_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data       = data_q;
  assign wraddress  = addr_q;
  assign wren       = wren_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Randomized and directed bench for pixel_packer with a per-cycle reference model
// and literal checks of the packed image memory contents.
module tb_pixel_packer;

  localparam int unsigned W   = 640;
  localparam int unsigned H   = 8;
  localparam int unsigned BPR = W / 8;
  localparam int unsigned NB  = W * H / 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic [7:0]  pix_gray;
  logic        sof;
  logic [7:0]  threshold;
  logic [7:0]  data;
  logic [15:0] wraddress;
  logic        wren;
  logic        frame_done;
  logic        overflow;

  pixel_packer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_gray   (pix_gray),
    .sof        (sof),
    .threshold  (threshold),
    .data       (data),
    .wraddress  (wraddress),
    .wren       (wren),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = waiting for sof, 1 = in frame, 2 = frame complete.
  int          m_mode, m_x, m_y;
  logic [7:0]  m_bits;
  logic        e_wren, e_done, e_ovf;
  logic [7:0]  e_data;
  logic [15:0] e_addr;

  always @(posedge clk) begin
    e_wren = 1'b0;
    e_done = 1'b0;
    if (reset) begin
      m_mode = 0; m_x = 0; m_y = 0; m_bits = 8'h00;
      e_data = 8'h00; e_addr = 16'h0000; e_ovf = 1'b0;
    end else if (pix_valid) begin
      if (sof) begin
        m_mode = 1; m_x = 0; m_y = 0; e_ovf = 1'b0;
      end else if (m_mode == 2) begin
        e_ovf = 1'b1;
      end
      if (m_mode == 1) begin
        m_bits[3'(m_x % 8)] = (pix_gray >= threshold);
        if (m_x % 8 == 7) begin
          e_wren = 1'b1;
          e_data = m_bits;
          e_addr = 16'(m_y * BPR + m_x / 8);
        end
        m_x++;
        if (m_x == W) begin
          m_x = 0;
          m_y++;
          if (m_y == H) begin
            m_mode = 2;
            e_done = 1'b1;
          end
        end
      end
    end
  end

  int          n_vec, n_fail;
  int          wr_count, done_count, last_addr, done_addr;
  logic [7:0]  mem [NB];
  int          seq [NB];
  int          snap, dsnap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then log what the DUT wrote.
  task automatic cmp_cycle();
    chk("wren", 32'(wren), 32'(e_wren));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("data", 32'(data), 32'(e_data));
    chk("wraddress", 32'(wraddress), 32'(e_addr));
    if (wren === 1'b1) begin
      wr_count++;
      last_addr = int'(wraddress);
      if (int'(wraddress) < NB) begin
        mem[int'(wraddress)] = data;
        seq[int'(wraddress)] = wr_count;
      end
      if (frame_done === 1'b1) begin
        done_count++;
        done_addr = int'(wraddress);
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] g, input logic s,
                      input logic [7:0] th, input logic r);
    pix_valid = v; pix_gray = g; sof = s; threshold = th; reset = r;
    @(posedge clk);
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic px(input logic [7:0] g, input logic s, input logic [7:0] th);
    step(1'b1, g, s, th, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'($urandom), 1'($urandom), 8'($urandom), 1'b0);
  endtask

  initial begin
    n_vec = 0; n_fail = 0; wr_count = 0; done_count = 0; last_addr = -1; done_addr = -1;
    for (int i = 0; i < NB; i++) begin
      mem[i] = 8'hAA;
      seq[i] = 0;
    end
    repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_addr", 32'(wraddress), 32'd0);

    // Pixels before any sof are ignored.
    for (int i = 0; i < 20; i++) px(8'hFF, 1'b0, 8'h00);
    chk("presof_writes", 32'(wr_count), 32'd0);

    // One line of black pixels.
    snap = wr_count;
    for (int x = 0; x < W; x++) px(8'h00, x == 0, 8'd128);
    chk("row0_writes", 32'(wr_count - snap), 32'd80);
    chk("row0_last_addr", 32'(last_addr), 32'd79);
    chk("row0_data79", 32'(mem[79]), 32'h00);

    // Sparse set pixels in rows 0 and 1 of a new frame.
    snap = wr_count;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < W; x++)
        px(((y == 0 && x == 8) || (y == 1 && (x == 1 || x == 10))) ? 8'd200 : 8'd0,
           (y == 0 && x == 0), 8'd128);
    chk("r0_addr0", 32'(mem[0]), 32'h00);
    chk("r0_addr1", 32'(mem[1]), 32'h01);
    chk("r1_addr80", 32'(mem[80]), 32'h02);
    chk("r1_addr81", 32'(mem[81]), 32'h04);
    chk("r1_addr81_new", 32'(seq[81] > snap), 32'd1);

    // 13 pixels into the next line, then an early sof with an equality edge.
    for (int x = 0; x < 13; x++) px(8'hFF, 1'b0, 8'h00);
    snap = wr_count; dsnap = done_count;
    for (int x = 0; x < 8; x++)
      px((x == 6) ? 8'd99 : (x == 7) ? 8'd100 : 8'd0, x == 0, 8'd100);
    chk("abort_writes", 32'(wr_count - snap), 32'd1);
    chk("abort_addr", 32'(last_addr), 32'd0);
    chk("eq_edge_data", 32'(mem[0]), 32'h80);
    chk("abort_no_done", 32'(done_count), 32'(dsnap));

    // Reset partway through a byte.
    snap = wr_count;
    px(8'hFF, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) px(8'hFF, 1'b0, 8'h00);
    step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b1);
    chk("midrst_writes", 32'(wr_count - snap), 32'd0);
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_addr", 32'(wraddress), 32'd0);
    idle();

    // Full frame, random content and thresholds, random valid gaps.
    snap = wr_count; dsnap = done_count;
    for (int p = 0; p < W * H; p++) begin
      while ($urandom_range(0, 3) == 0) idle();
      px(8'($urandom), p == 0, 8'($urandom));
    end
    chk("frame_writes", 32'(wr_count - snap), 32'(NB));
    chk("frame_last_addr", 32'(last_addr), 32'(H * BPR - 1));
    chk("frame_done_count", 32'(done_count - dsnap), 32'd1);
    chk("frame_done_addr", 32'(done_addr), 32'(H * BPR - 1));

    // Pixels after frame completion raise overflow and write nothing.
    snap = wr_count;
    for (int i = 0; i < 5; i++) begin
      px(8'($urandom), 1'b0, 8'($urandom));
      idle();
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_no_writes", 32'(wr_count - snap), 32'd0);
    px(8'h00, 1'b1, 8'h00);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    for (int x = 1; x < 16; x++) px(8'($urandom), 1'b0, 8'($urandom));
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Upstream writer for the 1-bit image memory that the pixel cache reads.
- Takes a raster stream of 8-bit grayscale camera pixels, thresholds each to 1 bit and packs 8 horizontally adjacent pixels into one byte.
- Writes each completed byte at address y*BYTES_PER_ROW + (x>>3), with pixel x stored in bit x%8 (LSB = leftmost).
- Drives the memory write port (data/wraddress/wren) directly.

Parameters:
WIDTH, 640, pixels per line; must be a multiple of 8
HEIGHT, 480, lines per frame
BYTES_PER_ROW, WIDTH/8 (80), bytes per memory row; derived, do not override

Ports:
clk  input  1  module clock
reset  input  1  synchronous, active-high reset
pix_valid  input  1  pix_gray/sof valid this cycle; one pixel accepted per cycle when high
pix_gray  input  8  grayscale pixel value
sof  input  1  start of frame; qualified by pix_valid; marks pixel (0,0)
threshold  input  8  binarization level; pixel bit = (pix_gray >= threshold)
data  output  8  packed byte to image memory
wraddress  output  16  image memory write address
wren  output  1  write strobe, one cycle per byte
frame_done  output  1  one-cycle pulse with the final byte write of a frame
overflow  output  1  sticky: a pixel arrived after frame completion and before the next sof

Behaviour:
- Reset values: data=0, wraddress=0, wren=0, frame_done=0, overflow=0. Internal x_cnt=0, y_cnt=0, shift byte=0, state=S_wait_sof.
- Reset mid-operation discards any partial byte; no write is issued.
- threshold is sampled in the same cycle as its pixel.
- S_wait_sof: pixels without sof are ignored (no counting, no write).
  - pix_valid&sof: pixel becomes (0,0), byte bit0 loads, x_cnt->1, state->S_active.
- S_active, per accepted pixel at (x_cnt,y_cnt):
  - Byte bit (x_cnt%8) = (pix_gray >= threshold).
  - When x_cnt%8==7, next cycle: wren=1, data = completed byte including this pixel, wraddress = y_cnt*BYTES_PER_ROW + (x_cnt>>3).
  - Write latency is exactly 1 cycle after the 8th pixel is accepted; wren is high for exactly one cycle per byte.
  - Back-to-back pixels produce one write every 8 accepted pixels; gaps in pix_valid stall counting with no effect on packing.
  - x_cnt wraps WIDTH-1 -> 0 and increments y_cnt.
  - After pixel (WIDTH-1, HEIGHT-1): state->S_done; frame_done=1 in the same cycle as that final wren (address HEIGHT*BYTES_PER_ROW-1 = 38399 at defaults).
- S_done: pix_valid without sof sets overflow=1; the pixel is dropped with no write.
  - pix_valid&sof: clears overflow, starts a new frame exactly as from S_wait_sof.
- sof in S_active (early/short frame): the pending partial byte is discarded (not written), counters restart at (0,0), and the sof pixel is packed as bit0. No frame_done is issued for the aborted frame.
- Bits of a byte are overwritten as pixels arrive, so stale bits never leak into a completed byte.
- Address arithmetic: y_cnt*BYTES_PER_ROW computed at ≥16 bits; the maximum address is 38399, so it never wraps at defaults.
- The y_cnt*80 multiply may be replaced by an incrementally maintained row-base register (+BYTES_PER_ROW per line). Either way, wraddress must be identical.
- wraddress/data hold their last written values while wren=0.

Test Plan:
- Reset, then 640 pixels with gray=0 (sof on the first), threshold=128 -> 80 writes, addresses 0..79, data=8'h00, one write per 8 valid cycles, wren 1 cycle after each 8th pixel.
- Row 0 with pixel x=8 gray=200, rest 0, threshold=128 -> write addr 1 data 8'h01; x=0..7 gives addr 0 data 8'h00. Row 1 with x=1 and x=10 set -> addr 80 data 8'h02, addr 81 data 8'h04.
- Equality edge: threshold=100, gray=100 at x=7 and gray=99 at x=6 -> addr 0 data 8'h80.
- Full 640x480 frame with random pix_valid gaps -> exactly 38400 writes, last addr 38399, frame_done high for exactly one cycle coincident with that wren; 5 extra pixels -> overflow=1 and no writes; next sof -> overflow=0.
- sof reasserted after 13 pixels of line 2 -> no write for the partial byte; the next completed byte writes addr 0. Also: pixels before the first sof after reset -> no writes.
- Reset asserted after 4 pixels of a byte -> no write; all outputs return to reset values; the next frame packs correctly from addr 0.
